// File: rtl/serial_transmitter.sv
`default_nettype none
// ==========================================================================
// serial_transmitter -- LSB-first parallel-to-serial stage with a one-entry
// holding buffer.                                              Revision: 1.0
// ==========================================================================
module serial_transmitter #(
  parameter int BAUD_PERIOD = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int GAP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  serial_out,
  output logic                  tx_enable,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int C_GAP_CYCLES = GAP_BITS * BAUD_PERIOD;
  localparam int CNT_W = (C_GAP_CYCLES > 1) ? $clog2(C_GAP_CYCLES) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] C_BAUD_LAST = CNT_W'(BAUD_PERIOD - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(C_GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [CNT_W-1:0]      baud_cnt_q, baud_cnt_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  serial_out_q, serial_out_d;
  logic                  tx_enable_q, tx_enable_d;
  logic                  tx_busy_q, tx_busy_d;
  logic                  tx_done_q, tx_done_d;

  logic                  w_load;
  logic                  w_shift;
  logic                  w_frame_end;
  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_shifted = shift_reg_q >> 1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_frame_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (buf_full_q) begin
          w_load  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (baud_cnt_q == C_BAUD_LAST) begin
          if (bit_idx_q == C_IDX_LAST) begin
            w_frame_end = 1'b1;
            state_d     = S_GAP;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (baud_cnt_q == C_GAP_LAST) begin
          if (buf_full_q) begin
            w_load  = 1'b1;
            state_d = S_SHIFT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Load and accept are mutually exclusive: a load needs a full buffer,
  // an accept needs an empty one.
  always_comb begin
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    shift_reg_d = shift_reg_q;
    baud_cnt_d  = baud_cnt_q;
    bit_idx_d   = bit_idx_q;

    if (w_load) begin
      shift_reg_d = buf_q;
      buf_full_d  = 1'b0;
      bit_idx_d   = '0;
    end else if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    if (w_shift) begin
      shift_reg_d = w_shifted;
      bit_idx_d   = bit_idx_q + IDX_W'(1);
    end

    // Any state change or bit boundary restarts the count, so it never wraps.
    if (w_shift || (state_d != state_q)) begin
      baud_cnt_d = '0;
    end else if (state_q != S_IDLE) begin
      baud_cnt_d = baud_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    serial_out_d = serial_out_q;
    tx_enable_d  = tx_enable_q;
    tx_done_d    = 1'b0;
    if (w_load) begin
      serial_out_d = buf_q[0];
      tx_enable_d  = 1'b1;
    end else if (w_shift) begin
      serial_out_d = w_shifted[0];
    end else if (w_frame_end) begin
      serial_out_d = 1'b1;
      tx_enable_d  = 1'b0;
      tx_done_d    = 1'b1;
    end
    tx_busy_d = (state_d != S_IDLE) || buf_full_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      shift_reg_q  <= '0;
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      serial_out_q <= 1'b1;
      tx_enable_q  <= 1'b0;
      tx_busy_q    <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      shift_reg_q  <= shift_reg_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      serial_out_q <= serial_out_d;
      tx_enable_q  <= tx_enable_d;
      tx_busy_q    <= tx_busy_d;
      tx_done_q    <= tx_done_d;
    end
  end

  assign tx_ready   = !buf_full_q;
  assign serial_out = serial_out_q;
  assign tx_enable  = tx_enable_q;
  assign tx_busy    = tx_busy_q;
  assign tx_done    = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tb_serial_transmitter -- directed bench for serial_transmitter.
//                                                              Revision: 1.0
// ==========================================================================
module tb_serial_transmitter;

  localparam int BAUD    = 10;
  localparam int GAP_CYC = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, serial_out, tx_enable, tx_busy, tx_done;

  logic       reset2;
  logic [7:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2, serial_out2, tx_enable2, tx_busy2, tx_done2;

  int n_tests = 0;
  int n_fail  = 0;

  serial_transmitter dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .serial_out (serial_out),
    .tx_enable  (tx_enable),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  serial_transmitter #(
    .BAUD_PERIOD (2),
    .DATA_WIDTH  (8),
    .GAP_BITS    (3)
  ) dut2 (
    .clk        (clk),
    .reset      (reset2),
    .tx_data    (tx_data2),
    .tx_valid   (tx_valid2),
    .tx_ready   (tx_ready2),
    .serial_out (serial_out2),
    .tx_enable  (tx_enable2),
    .tx_busy    (tx_busy2),
    .tx_done    (tx_done2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called with the current sample at frame cycle 'start' (0 = just after the load edge).
  task automatic expect_frame(input logic [7:0] data, input int start, input string tag);
    for (int i = start; i < 8 * BAUD; i++) begin
      if (i != start) tick();
      check({tag, "_bit"}, 32'({tx_enable, tx_done, serial_out}), 32'({2'b10, data[i / BAUD]}));
    end
    tick();
    check({tag, "_end"}, 32'({tx_enable, tx_done, serial_out}), 32'(3'b011));
  endtask

  // Called just after the frame-end edge; returns just after the gap-end edge.
  task automatic gap_then(input bit expect_idle, input string tag);
    for (int k = 1; k < GAP_CYC; k++) begin
      tick();
      check({tag, "_gap"}, 32'({tx_enable, tx_done, serial_out, tx_busy}), 32'(4'b0011));
    end
    tick();
    if (expect_idle)
      check({tag, "_idle"}, 32'({tx_busy, tx_enable, tx_ready, serial_out}), 32'(4'b0011));
  endtask

  logic       pre_ready;
  logic [7:0] rx_byte;
  logic [7:0] rx_got [3];
  int         acc_edge [3];
  int         n_acc, n_done, en_cnt;

  initial begin
    reset     = 1'b0;
    reset2    = 1'b0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    tx_data2  = 8'h00;
    tx_valid2 = 1'b0;

    // Reset
    repeat (5) tick();
    check("rst_hold", 32'({tx_ready, serial_out, tx_enable, tx_busy, tx_done}), 32'(5'b11000));
    reset  = 1'b1;
    reset2 = 1'b1;
    tick();
    check("rst_rel", 32'({tx_ready, serial_out, tx_enable, tx_busy, tx_done}), 32'(5'b11000));
    check("rst_rel2", 32'({tx_ready2, serial_out2, tx_enable2, tx_busy2, tx_done2}), 32'(5'b11000));

    // Single byte 0xA5
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("one_acc", 32'({tx_ready, tx_busy, tx_enable, serial_out}), 32'(4'b0101));
    tick();
    expect_frame(8'hA5, 0, "one");
    gap_then(1'b1, "one");

    // Back-to-back 0x3C then 0xC3
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    tick();
    check("b2b_acc0", 32'(tx_ready), 32'(0));
    tx_data = 8'hC3;
    tick();
    check("b2b_load", 32'({tx_enable, serial_out, tx_ready}), 32'(3'b101));
    tick();
    tx_valid = 1'b0;
    check("b2b_acc1", 32'({tx_ready, tx_busy}), 32'(2'b01));
    expect_frame(8'h3C, 1, "b2b_a");
    gap_then(1'b0, "b2b");
    expect_frame(8'hC3, 0, "b2b_b");
    gap_then(1'b1, "b2b");

    // Backpressure: valid held high across three bytes
    tx_data  = 8'h11;
    tx_valid = 1'b1;
    n_acc    = 0;
    n_done   = 0;
    en_cnt   = 0;
    rx_byte  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      rx_got[i]   = 8'h00;
      acc_edge[i] = -1;
    end
    for (int cyc = 0; cyc < 400 && n_done < 3; cyc++) begin
      pre_ready = tx_ready;
      tick();
      if (pre_ready && tx_valid) begin
        if (n_acc < 3) acc_edge[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) tx_data = 8'h22;
        else if (n_acc == 2) tx_data = 8'h33;
        else tx_valid = 1'b0;
      end
      if (tx_enable) begin
        if (en_cnt % BAUD == 4) rx_byte = {serial_out, rx_byte[7:1]};
        en_cnt++;
      end else begin
        en_cnt = 0;
      end
      if (tx_done) begin
        if (n_done < 3) rx_got[n_done] = rx_byte;
        n_done++;
      end
    end
    tx_valid = 1'b0;
    check("bp_n_acc", 32'(n_acc), 32'(3));
    check("bp_n_done", 32'(n_done), 32'(3));
    check("bp_edge0", 32'(acc_edge[0]), 32'(0));
    check("bp_edge1", 32'(acc_edge[1]), 32'(2));
    check("bp_edge2", 32'(acc_edge[2]), 32'(92));
    check("bp_rx0", 32'(rx_got[0]), 32'(8'h11));
    check("bp_rx1", 32'(rx_got[1]), 32'(8'h22));
    check("bp_rx2", 32'(rx_got[2]), 32'(8'h33));
    repeat (GAP_CYC) tick();
    check("bp_idle", 32'({tx_busy, tx_enable, tx_ready}), 32'(3'b001));

    // Reset mid-frame, with a second byte sitting in the buffer
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick();
    tx_data = 8'h55;
    tick();
    tick();
    tx_valid = 1'b0;
    check("mid_buf", 32'(tx_ready), 32'(0));
    repeat (33) tick();
    check("mid_pre", 32'({tx_enable, serial_out, tx_busy}), 32'(3'b111));
    reset = 1'b0;
    #1;
    check("mid_async", 32'({tx_ready, serial_out, tx_enable, tx_busy, tx_done}), 32'(5'b11000));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_nodone", 32'({tx_done, tx_enable}), 32'(0));
    end
    reset = 1'b1;
    repeat (3) tick();
    check("mid_drop", 32'({tx_ready, serial_out, tx_enable, tx_busy, tx_done}), 32'(5'b11000));
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    expect_frame(8'h01, 0, "mid_next");
    gap_then(1'b1, "mid_next");

    // BAUD_PERIOD=2, GAP_BITS=3 with 0x80
    tx_data2  = 8'h80;
    tx_valid2 = 1'b1;
    tick();
    tx_valid2 = 1'b0;
    check("sw_acc", 32'({tx_ready2, tx_busy2}), 32'(2'b01));
    for (int k = 1; k <= 23; k++) begin
      tick();
      check("sw_cyc",
            32'({tx_enable2, serial_out2, tx_done2, tx_busy2}),
            32'({(k <= 16), (k >= 15), (k == 17), (k <= 22)}));
    end
    check("sw_idle", 32'({tx_busy2, tx_ready2, serial_out2}), 32'(3'b011));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
